// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : RV32I load/store unit with a single-beat data-memory port,
//            legality checking and a bounded wait for the memory ack.
// Revision : 1.0
// ============================================================================
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic        mem_we,
    input  logic [2:0]  mem_funct3,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] data_m,
    output logic        mem_done,
    output logic        mem_exc,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata
);

    localparam logic [16:0] C_TIMEOUT = 17'(TIMEOUT);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] data_m_q, data_m_d;
    logic        done_q, done_d;
    logic        exc_q, exc_d;
    logic        dm_req_q, dm_req_d;
    logic        dm_we_q, dm_we_d;
    logic [31:0] dm_addr_q, dm_addr_d;
    logic [3:0]  dm_be_q, dm_be_d;
    logic [31:0] dm_wdata_q, dm_wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;

    logic        funct3_ok;
    logic        misaligned;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [31:0] byte_shift;
    logic [31:0] half_shift;
    logic [31:0] load_val;
    logic [16:0] cnt_inc;

    // Request decode: legality, lane enables and lane-replicated store data
    always_comb begin
        funct3_ok  = 1'b0;
        misaligned = 1'b0;
        be_calc    = 4'b1111;
        wdata_calc = 32'd0;

        if (mem_we) begin
            funct3_ok = (mem_funct3 == 3'b000) || (mem_funct3 == 3'b001) ||
                        (mem_funct3 == 3'b010);
        end else begin
            funct3_ok = (mem_funct3 == 3'b000) || (mem_funct3 == 3'b001) ||
                        (mem_funct3 == 3'b010) || (mem_funct3 == 3'b100) ||
                        (mem_funct3 == 3'b101);
        end

        case (mem_funct3[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << mem_addr[1:0];
                wdata_calc = {4{mem_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = mem_addr[0];
                be_calc    = 4'b0011 << {mem_addr[1], 1'b0};
                wdata_calc = {2{mem_wdata[15:0]}};
            end
            default: begin
                misaligned = (mem_addr[1:0] != 2'b00);
                be_calc    = 4'b1111;
                wdata_calc = mem_wdata;
            end
        endcase

        if (!mem_we) begin
            wdata_calc = 32'd0;
        end
    end

    // Load extraction uses the offset and width captured at accept
    always_comb begin
        byte_shift = dm_rdata >> {off_q, 3'b000};
        half_shift = dm_rdata >> {off_q[1], 4'b0000};
        case (f3_q)
            3'b000:  load_val = {{24{byte_shift[7]}}, byte_shift[7:0]};
            3'b001:  load_val = {{16{half_shift[15]}}, half_shift[15:0]};
            3'b100:  load_val = {24'd0, byte_shift[7:0]};
            3'b101:  load_val = {16'd0, half_shift[15:0]};
            default: load_val = dm_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_m_d   = data_m_q;
        done_d     = 1'b0;
        exc_d      = 1'b0;
        dm_req_d   = dm_req_q;
        dm_we_d    = dm_we_q;
        dm_addr_d  = dm_addr_q;
        dm_be_d    = dm_be_q;
        dm_wdata_d = dm_wdata_q;
        f3_d       = f3_q;
        off_d      = off_q;
        cnt_inc    = {1'b0, cnt_q} + 17'd1;

        case (state_q)
            IDLE: begin
                if (mem_valid) begin
                    if (!funct3_ok || misaligned) begin
                        exc_d = 1'b1;
                    end else begin
                        state_d    = BUSY;
                        cnt_d      = 16'd0;
                        dm_req_d   = 1'b1;
                        dm_we_d    = mem_we;
                        dm_addr_d  = {mem_addr[31:2], 2'b00};
                        dm_be_d    = be_calc;
                        dm_wdata_d = wdata_calc;
                        f3_d       = mem_funct3;
                        off_d      = mem_addr[1:0];
                    end
                end
            end
            BUSY: begin
                // An ack arriving on the final allowed cycle still completes
                if (dm_ack) begin
                    state_d  = IDLE;
                    dm_req_d = 1'b0;
                    done_d   = 1'b1;
                    if (!dm_we_q) begin
                        data_m_d = load_val;
                    end
                end else if (cnt_inc >= C_TIMEOUT) begin
                    state_d  = IDLE;
                    dm_req_d = 1'b0;
                    exc_d    = 1'b1;
                end else begin
                    cnt_d = cnt_inc[15:0];
                end
            end
            default: begin
                state_d  = IDLE;
                dm_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 16'd0;
            data_m_q   <= 32'd0;
            done_q     <= 1'b0;
            exc_q      <= 1'b0;
            dm_req_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= 32'd0;
            dm_be_q    <= 4'd0;
            dm_wdata_q <= 32'd0;
            f3_q       <= 3'd0;
            off_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_m_q   <= data_m_d;
            done_q     <= done_d;
            exc_q      <= exc_d;
            dm_req_q   <= dm_req_d;
            dm_we_q    <= dm_we_d;
            dm_addr_q  <= dm_addr_d;
            dm_be_q    <= dm_be_d;
            dm_wdata_q <= dm_wdata_d;
            f3_q       <= f3_d;
            off_q      <= off_d;
        end
    end

    assign mem_ready = (state_q == IDLE);
    assign data_m    = data_m_q;
    assign mem_done  = done_q;
    assign mem_exc   = exc_q;
    assign dm_req    = dm_req_q;
    assign dm_we     = dm_we_q;
    assign dm_addr   = dm_addr_q;
    assign dm_be     = dm_be_q;
    assign dm_wdata  = dm_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Vector table, reset corner case and random transactions against
//            a transaction-level model of the load/store unit.
// Revision : 1.0
// ============================================================================
module tb_load_store_unit;

    localparam int C_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic        mem_we = 1'b0;
    logic [2:0]  mem_funct3 = 3'd0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic [31:0] data_m;
    logic        mem_done;
    logic        mem_exc;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_ack = 1'b0;
    logic [31:0] dm_rdata = 32'd0;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_dm = 32'd0;

    load_store_unit #(.TIMEOUT(C_TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_funct3 (mem_funct3),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .data_m     (data_m),
        .mem_done   (mem_done),
        .mem_exc    (mem_exc),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_be      (dm_be),
        .dm_wdata   (dm_wdata),
        .dm_ack     (dm_ack),
        .dm_rdata   (dm_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    function automatic int nbytes(input logic [2:0] f3);
        return 1 << int'(f3 % 4);
    endfunction

    function automatic logic m_legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
        int n;
        logic ok;
        if (we) ok = (f3 <= 3'd2);
        else    ok = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
        if (!ok) return 1'b0;
        n = nbytes(f3);
        return (int'(a % 4) % n) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        longint mask;
        mask = (longint'(1) << nbytes(f3)) - 1;
        return 4'(mask << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic we, input logic [2:0] f3, input logic [31:0] wd);
        if (!we) return 32'd0;
        case (nbytes(f3))
            1:       return (wd & 32'hFF) * 32'h0101_0101;
            2:       return (wd & 32'hFFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int     bits;
        longint v;
        bits = 8 * nbytes(f3);
        if (bits == 32) return rd;
        v = (longint'(rd) >> (8 * (a % 4))) & ((longint'(1) << bits) - 1);
        if (f3[2] == 1'b0 && v >= (longint'(1) << (bits - 1)))
            v = v - (longint'(1) << bits);
        return 32'(v);
    endfunction

    // One request from an IDLE negedge; ends at the negedge of the result cycle.
    // delay = BUSY cycles without ack before ack; delay >= C_TIMEOUT means no ack.
    task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd, input int delay,
                          input logic legal, input logic [3:0] be, input logic [31:0] ewd,
                          input logic [31:0] edm);
        chk("ready_before", mem_ready, 1'b1);
        mem_valid  = 1'b1;
        mem_we     = we;
        mem_funct3 = f3;
        mem_addr   = addr;
        mem_wdata  = wd;
        dm_ack     = 1'($urandom % 2);
        dm_rdata   = $urandom;
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        dm_ack    = 1'b0;
        if (!legal) begin
            @(negedge clk);
            chk("exc_illegal", mem_exc, 1'b1);
            chk("done_illegal", mem_done, 1'b0);
            chk("req_illegal", dm_req, 1'b0);
            chk("ready_illegal", mem_ready, 1'b1);
            chk("data_m_illegal", data_m, edm);
        end else begin
            for (int k = 0; k < C_TIMEOUT; k++) begin
                @(negedge clk);
                chk("req_busy", dm_req, 1'b1);
                chk("we_busy", dm_we, we);
                chk("addr_busy", dm_addr, {addr[31:2], 2'b00});
                chk("be_busy", dm_be, be);
                chk("wdata_busy", dm_wdata, ewd);
                chk("ready_busy", mem_ready, 1'b0);
                chk("done_busy", mem_done, 1'b0);
                chk("exc_busy", mem_exc, 1'b0);
                mem_valid = 1'($urandom % 2);
                if (k == delay) begin
                    dm_ack   = 1'b1;
                    dm_rdata = rd;
                end else begin
                    dm_ack   = 1'b0;
                    dm_rdata = $urandom;
                end
                @(posedge clk);
                #1;
                mem_valid = 1'b0;
                dm_ack    = 1'b0;
                if (k == delay) break;
            end
            @(negedge clk);
            if (delay < C_TIMEOUT) begin
                chk("done_ack", mem_done, 1'b1);
                chk("exc_ack", mem_exc, 1'b0);
            end else begin
                chk("done_timeout", mem_done, 1'b0);
                chk("exc_timeout", mem_exc, 1'b1);
            end
            chk("req_after", dm_req, 1'b0);
            chk("ready_after", mem_ready, 1'b1);
            chk("data_m_after", data_m, edm);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        int          delay;
        logic        legal;
        logic [3:0]  be;
        logic [31:0] ewd;
        logic [31:0] edm;
    } vec_t;

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{1'b0, 3'b000, 32'h0000_0103, 32'h0,         32'h80FF_1234, 0, 1'b1, 4'b1000, 32'h0,         32'hFFFF_FF80};
        tbl[1]  = '{1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0,         0, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'hFFFF_FF80};
        tbl[2]  = '{1'b0, 3'b010, 32'h0000_0006, 32'h0,         32'h0,         0, 1'b0, 4'b0000, 32'h0,         32'hFFFF_FF80};
        tbl[3]  = '{1'b0, 3'b101, 32'h0000_0002, 32'h0,         32'h0,         4, 1'b1, 4'b1100, 32'h0,         32'hFFFF_FF80};
        tbl[4]  = '{1'b0, 3'b101, 32'h0000_0002, 32'h0,         32'h8001_0000, 3, 1'b1, 4'b1100, 32'h0,         32'h0000_8001};
        tbl[5]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,         32'h1234_5678, 0, 1'b1, 4'b1111, 32'h0,         32'h1234_5678};
        tbl[6]  = '{1'b1, 3'b000, 32'h0000_0101, 32'h1234_56A5, 32'h0,         0, 1'b1, 4'b0010, 32'hA5A5_A5A5, 32'h1234_5678};
        tbl[7]  = '{1'b0, 3'b011, 32'h0000_0000, 32'h0,         32'h0,         0, 1'b0, 4'b0000, 32'h0,         32'h1234_5678};
        tbl[8]  = '{1'b1, 3'b100, 32'h0000_0000, 32'h0,         32'h0,         0, 1'b0, 4'b0000, 32'h0,         32'h1234_5678};
        tbl[9]  = '{1'b0, 3'b001, 32'h0000_0001, 32'h0,         32'h0,         0, 1'b0, 4'b0000, 32'h0,         32'h1234_5678};
        tbl[10] = '{1'b0, 3'b001, 32'h0000_0002, 32'h0,         32'h8001_0000, 1, 1'b1, 4'b1100, 32'h0,         32'hFFFF_8001};
        tbl[11] = '{1'b0, 3'b100, 32'h0000_0001, 32'h0,         32'h0000_9A00, 2, 1'b1, 4'b0010, 32'h0,         32'h0000_009A};
        tbl[12] = '{1'b1, 3'b010, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0,         4, 1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h0000_009A};
        tbl[13] = '{1'b1, 3'b010, 32'h0000_000C, 32'h0102_0304, 32'h0,         3, 1'b1, 4'b1111, 32'h0102_0304, 32'h0000_009A};

        // reset state, asynchronously applied from time zero
        #2;
        chk("rst_ready", mem_ready, 1'b1);
        chk("rst_req", dm_req, 1'b0);
        chk("rst_data_m", data_m, 32'h0);
        chk("rst_done", mem_done, 1'b0);
        chk("rst_exc", mem_exc, 1'b0);
        chk("rst_be", dm_be, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            do_txn(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, tbl[i].rd, tbl[i].delay,
                   tbl[i].legal, tbl[i].be, tbl[i].ewd, tbl[i].edm);
        end

        // reset while a store is in flight
        mem_valid  = 1'b1;
        mem_we     = 1'b1;
        mem_funct3 = 3'b010;
        mem_addr   = 32'h0000_0040;
        mem_wdata  = 32'h5555_AAAA;
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        @(negedge clk);
        chk("sw_req_pre_rst", dm_req, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_busy_req", dm_req, 1'b0);
        chk("rst_busy_we", dm_we, 1'b0);
        chk("rst_busy_addr", dm_addr, 32'h0);
        chk("rst_busy_be", dm_be, 4'h0);
        chk("rst_busy_wdata", dm_wdata, 32'h0);
        chk("rst_busy_ready", mem_ready, 1'b1);
        chk("rst_busy_data_m", data_m, 32'h0);
        chk("rst_busy_done", mem_done, 1'b0);
        chk("rst_busy_exc", mem_exc, 1'b0);
        exp_dm = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("post_rst_done", mem_done, 1'b0);
            chk("post_rst_exc", mem_exc, 1'b0);
            chk("post_rst_ready", mem_ready, 1'b1);
        end
        exp_dm = 32'hCAFE_F00D;
        do_txn(1'b0, 3'b010, 32'h0000_0044, 32'h0, 32'hCAFE_F00D, 0, 1'b1, 4'b1111, 32'h0, exp_dm);

        // random transactions against the model
        for (int n = 0; n < 200; n++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] addr, wd, rd;
            int          delay;
            logic        legal;
            we    = 1'($urandom % 2);
            f3    = 3'($urandom % 8);
            if ($urandom % 4 != 0) f3[1:0] = 2'($urandom % 3);
            if (we && ($urandom % 4 != 0)) f3[2] = 1'b0;
            addr  = $urandom;
            wd    = $urandom;
            rd    = $urandom;
            delay = int'($urandom_range(0, C_TIMEOUT));
            legal = m_legal(we, f3, addr);
            if (legal && !we && delay < C_TIMEOUT) exp_dm = m_load(f3, addr, rd);
            do_txn(we, f3, addr, wd, rd, delay, legal,
                   legal ? m_be(f3, addr) : 4'h0, m_wdata(we, f3, wd), exp_dm);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles in BUSY without DM_ACK before abort (legal range 1..65535).
REQ-002 CLK  in  1  sole clock; all state changes on rising edge.
REQ-003 RST_N  in  1  reset, asynchronous, active-low.
REQ-004 MEM_VALID  in  1  pipeline request valid.
REQ-005 MEM_READY  out  1  unit can accept a request; high exactly when state is IDLE.
REQ-006 MEM_WE  in  1  1 = store, 0 = load.
REQ-007 MEM_FUNCT3  in  3  RV32I funct3: loads LB=000, LH=001, LW=010, LBU=100, LHU=101; stores SB=000, SH=001, SW=010.
REQ-008 MEM_ADDR  in  32  byte address.
REQ-009 MEM_WDATA  in  32  store data, right-aligned.
REQ-010 DATA_M  out  32  load result toward the writeback select.
REQ-011 MEM_DONE  out  1  one-cycle pulse: access completed.
REQ-012 MEM_EXC  out  1  one-cycle pulse: misaligned, illegal funct3 or bus timeout.
REQ-013 DM_REQ / DM_WE  out  1 / 1  data-memory request, write enable.
REQ-014 DM_ADDR  out  32  word address: MEM_ADDR[31:2], 2'b00.
REQ-015 DM_BE / DM_WDATA  out  4 / 32  byte enables, lane-positioned write data.
REQ-016 DM_ACK / DM_RDATA  in  1 / 32  memory acknowledge, read word (valid in ACK cycle).

Function
REQ-017 FSM states IDLE, BUSY; request accepted on the edge where MEM_VALID && MEM_READY.
REQ-018 Legality check at accept: illegal funct3 (load 011/110/111, store >=011) or misalignment (halfword addr[0]=1, word addr[1:0]!=0) -> no bus access, stay IDLE, MEM_EXC pulse in next cycle, DATA_M unchanged.
REQ-019 Legal accept -> BUSY next cycle; DM_REQ, DM_WE, DM_ADDR, DM_BE, DM_WDATA registered and held constant until the ACK cycle.
REQ-020 Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111; same for loads and stores.
REQ-021 Store data: SB byte replicated to all 4 lanes; SH halfword replicated to both halves; SW unchanged; loads drive DM_WDATA=0.
REQ-022 DM_ACK high in BUSY -> next cycle: IDLE, DM_REQ=0, MEM_DONE=1; for loads DATA_M = extracted value.
REQ-023 Load extraction: lane selected by captured addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW full word.
REQ-024 DATA_M holds last load result until next completed load; stores and exceptions do not modify it.
REQ-025 Minimum latency: accept edge N, DM_REQ high cycle N+1, ACK at N+1 -> MEM_DONE/DATA_M at N+2; back-to-back accept allowed in cycle N+2.
REQ-026 16-bit wait counter cleared on entering BUSY, increments each BUSY cycle without ACK; at TIMEOUT reached -> IDLE, DM_REQ=0, MEM_EXC pulse, no MEM_DONE.
REQ-027 ACK in the same cycle the counter reaches TIMEOUT: ACK wins, normal completion, no MEM_EXC.
REQ-028 DM_ACK while IDLE ignored; MEM_VALID while BUSY ignored (MEM_READY=0).
REQ-029 MEM_DONE and MEM_EXC never high in the same cycle.

Reset
REQ-030 RST_N low asynchronously forces IDLE, counter 0, DATA_M=0, MEM_DONE=0, MEM_EXC=0, DM_REQ=0, DM_WE=0, DM_ADDR=0, DM_BE=0, DM_WDATA=0; MEM_READY=1.
REQ-031 Reset during BUSY abandons the transaction: DM_REQ drops immediately, no MEM_DONE/MEM_EXC after release.

Verification
REQ-032 LB addr 0x103, DM_RDATA=0x80FF_1234, ACK next cycle -> DM_BE=4'b1000, DATA_M=0xFFFF_FF80, MEM_DONE one cycle.
REQ-033 SH addr 0x202, MEM_WDATA=0x0000_ABCD -> DM_ADDR=0x200, DM_BE=4'b1100, DM_WDATA=0xABCD_ABCD, DM_WE=1; DATA_M unchanged.
REQ-034 LW addr 0x0000_0006 -> DM_REQ never asserted, MEM_EXC pulse next cycle, MEM_READY stays 1.
REQ-035 TIMEOUT=4, LHU with no ACK -> DM_REQ high 4 cycles, then MEM_EXC pulse, IDLE; repeat with ACK in 4th cycle, DM_RDATA=0x8001_0000, addr 0x2 -> DATA_M=0x0000_8001, no MEM_EXC.
REQ-036 RST_N low during BUSY of SW -> DM_REQ=0 same cycle, all outputs at reset values; after release, new LW completes normally.
REQ-037 Back-to-back: LW then SB with ACK every first BUSY cycle -> accepts at N and N+2, MEM_DONE at N+2 and N+4.
